snake_pixel_gen: RTL and testbench
==================================

SNAKE_PIXEL_GEN -- requirements
Module: snake_pixel_gen

Interface
REQ-001 SHALL have parameter CELL_SIZE, default 20, meaning pixel width/height of one grid cell.
REQ-002 SHALL have parameter GRID_W, default 40, meaning cells per row.
REQ-003 SHALL have parameter GRID_H, default 30, meaning cells per column.
REQ-004 SHALL have port vga_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pixel_xpos  input  11  requested pixel column, 0..799 while requested, else 0.
REQ-007 SHALL have port pixel_ypos  input  11  requested pixel row, 1..600 while requested, else 0.
REQ-008 SHALL have port pixel_data  output  16  RGB565 colour of the requested pixel.
REQ-009 SHALL have port wr_en  input  1  game-logic cell write strobe.
REQ-010 SHALL have port wr_addr  input  11  cell index, row*GRID_W+col.
REQ-011 SHALL have port wr_data  input  2  cell code: 0 empty, 1 body, 2 head, 3 food.
REQ-012 SHALL have port wr_ready  output  1  high when writes are accepted.
REQ-013 SHALL have port clr_req  input  1  single-cycle request to clear the whole grid.
REQ-014 SHALL have port clr_busy  output  1  high while clearing.
REQ-015 SHALL have port clr_done  output  1  one-cycle pulse on clear completion.

Function
REQ-016 SHALL map pixels to cells: col = pixel_xpos / CELL_SIZE; row = (pixel_ypos - 1) / CELL_SIZE; pixel_ypos 0 treated as row 0.
REQ-017 SHALL hold a GRID_W*GRID_H x 2-bit cell store (1200 entries), one write port, one synchronous read port.
REQ-018 SHALL present pixel_data exactly 1 vga_clk after pixel_xpos/pixel_ypos are presented (matches driver's one-cycle-early request).
REQ-019 SHALL colour: border cell (row 0, row GRID_H-1, col 0, col GRID_W-1) 16'hFFFF regardless of stored code; otherwise code 0 16'h0000, 1 16'h07E0, 2 16'hFFE0, 3 16'hF800.
REQ-020 SHALL use a two-state FSM: CLEAR (writes code 0 to addresses 0..1199, one per cycle, ascending) and IDLE.
REQ-021 SHALL go CLEAR->IDLE after writing address 1199, pulsing clr_done for exactly that transition cycle+1 (first IDLE cycle).
REQ-022 SHALL go IDLE->CLEAR on clr_req, restarting at address 0; clr_req in CLEAR ignored.
REQ-023 SHALL drive wr_ready = (state==IDLE), clr_busy = (state==CLEAR).
REQ-024 SHALL accept a write only when wr_en && wr_ready && wr_addr < 1200; all other writes silently dropped.
REQ-025 SHALL give read-old-data on same-cycle read/write of one address; new data visible next read.
REQ-026 SHALL, when wr_en and clr_req coincide in IDLE, perform the write and enter CLEAR next cycle (write then overwritten).
REQ-027 SHALL keep pixel output active during CLEAR (partially cleared grid may be displayed).

Reset
REQ-028 SHALL on reset: pixel_data 16'h0000, state CLEAR at address 0, clr_busy 1, wr_ready 0, clr_done 0; reset mid-clear restarts at 0.
REQ-029 SHALL not reset cell-store contents directly; the post-reset clear initialises them within 1200 cycles.

Configuration
REQ-030 SHALL, with SNAKE_GRID_LINES_EN defined, colour non-border pixels with (pixel_xpos % CELL_SIZE == 0) or ((pixel_ypos-1) % CELL_SIZE == 0) as 16'h4208 when cell code is 0; without it, no grid lines.

Structure
REQ-031 SHALL place cell codes, RGB565 colour constants and grid defaults in shared package snake_pkg.
REQ-032 SHALL implement the cell store as sub-module snake_cell_ram (1200x2, 1W/1R, synchronous read).

Verification
REQ-033 SHALL test reset release: clr_busy 1 for exactly 1200 cycles, clr_done pulses once, then wr_ready 1.
REQ-034 SHALL test write addr 41 code 2, then request x=20,y=21 -> pixel_data 16'hFFE0 one cycle later.
REQ-035 SHALL test request x=0,y=1 (border) with code 3 written at addr 0 -> 16'hFFFF.
REQ-036 SHALL test write addr 1200 code 1 and write during CLEAR -> no store change, reads of addr 1199 stay 16'hFFFF border / cell data unchanged.
REQ-037 SHALL test same-cycle write addr 85 code 3 and read of cell 85 -> old colour, next read 16'hF800.
REQ-038 SHALL test reset asserted at clear address 600 -> clear restarts from 0, clr_busy 1 for 1200 further cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg -- shared definitions for the snake display pixel generator.
//   * grid defaults (cell size, grid width/height)
//   * cell codes stored in the cell RAM
//   * RGB565 colour constants and the code -> colour lookup
//   * clear FSM state encoding
// Optional feature macro used by the importing RTL: SNAKE_GRID_LINES_EN.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int CELL_SIZE_DEF = 20;
    localparam int GRID_W_DEF    = 40;
    localparam int GRID_H_DEF    = 30;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BODY  = 2'd1,
        CELL_HEAD  = 2'd2,
        CELL_FOOD  = 2'd3
    } cell_code_e;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_GRID   = 16'h4208;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic logic [15:0] cell_colour(input logic [1:0] code);
        logic [15:0] c;
        case (cell_code_e'(code))
            CELL_BODY: c = RGB_GREEN;
            CELL_HEAD: c = RGB_YELLOW;
            CELL_FOOD: c = RGB_RED;
            default:   c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/snake_cell_ram.sv
// -----------------------------------------------------------------------------
// snake_cell_ram -- DEPTH x 2-bit cell store, one write port, one synchronous
// read port. A read and write of the same address in one cycle returns the
// old contents; the new value is seen on the following read.
// Only the read register is reset; the array itself is initialised by the
// clear sequence in the parent.
// Ports:
//   vga_clk, sys_rst_n   clock / async active-low reset (read register only)
//   we, wr_addr, wr_data write strobe, cell index, cell code
//   rd_addr, rd_data     read index, registered cell code (0 when out of range)
// -----------------------------------------------------------------------------
module snake_cell_ram import snake_pkg::*; #(
    parameter int DEPTH = GRID_W_DEF * GRID_H_DEF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        we,
    input  logic [10:0] wr_addr,
    input  logic [1:0]  wr_data,
    input  logic [10:0] rd_addr,
    output logic [1:0]  rd_data
);

    logic [1:0] mem [DEPTH];
    logic [1:0] rd_data_d, rd_data_q;

    always_ff @(posedge vga_clk) begin
        if (we && (32'(wr_addr) < 32'(DEPTH)))
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = 2'd0;
        if (32'(rd_addr) < 32'(DEPTH))
            rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rd_data_q <= 2'd0;
        else            rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/snake_pixel_gen.sv
// -----------------------------------------------------------------------------
// snake_pixel_gen -- turns a VGA pixel request into an RGB565 colour from a
// cell grid written by the game logic. Colour appears one clock after the
// request. After reset (or clr_req) the grid is cleared one cell per clock.
// Optional macro: SNAKE_GRID_LINES_EN -- draw grey grid lines on the first
// pixel column/row of each empty, non-border cell.
// Ports:
//   vga_clk, sys_rst_n        pixel clock / async active-low reset
//   pixel_xpos, pixel_ypos    requested pixel (ypos is 1-based, 0 = idle)
//   pixel_data                RGB565 colour, one clock after the request
//   wr_en, wr_addr, wr_data   cell write from game logic (row*GRID_W+col)
//   wr_ready                  writes accepted (not clearing)
//   clr_req                   start a full grid clear
//   clr_busy, clr_done        clearing in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module snake_pixel_gen import snake_pkg::*; #(
    parameter int CELL_SIZE = CELL_SIZE_DEF,
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic [15:0] pixel_data,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [1:0]  wr_data,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam int DEPTH = GRID_W * GRID_H;

    // ---------------- clear FSM ----------------
    clr_state_e  state_d, state_q;
    logic [10:0] clr_addr_d, clr_addr_q;
    logic        clr_done_d, clr_done_q;
    logic        wr_ready_d, wr_ready_q;
    logic        clr_busy_d, clr_busy_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == 11'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 11'd0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 11'd1;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = 11'd0;
                end
            end
        endcase
        // Status outputs are registered copies of the next state.
        wr_ready_d = (state_d == ST_IDLE);
        clr_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 11'd0;
            clr_done_q <= 1'b0;
            wr_ready_q <= 1'b0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
            wr_ready_q <= wr_ready_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // ---------------- RAM write mux ----------------
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [1:0]  ram_wdata;

    always_comb begin
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = CELL_EMPTY;
        end else begin
            ram_we    = wr_en && (32'(wr_addr) < 32'(DEPTH));
            ram_waddr = wr_addr;
            ram_wdata = wr_data;
        end
    end

    // ---------------- pixel -> cell mapping ----------------
    logic [31:0] y_off, col, row, rd_idx;
    logic [10:0] rd_addr;
    logic        border_d, border_q;
    logic        grid_d, grid_q;

    always_comb begin
        // ypos is 1-based; 0 means no active request and maps onto row 0.
        y_off    = (pixel_ypos == 11'd0) ? 32'd0 : 32'(pixel_ypos) - 32'd1;
        col      = 32'(pixel_xpos) / 32'(CELL_SIZE);
        row      = y_off / 32'(CELL_SIZE);
        rd_idx   = row * 32'(GRID_W) + col;
        rd_addr  = rd_idx[10:0];
        // ">=" also folds off-grid requests into the border colour.
        border_d = (row == 32'd0) || (row >= 32'(GRID_H - 1)) ||
                   (col == 32'd0) || (col >= 32'(GRID_W - 1));
`ifdef SNAKE_GRID_LINES_EN
        grid_d   = ((32'(pixel_xpos) % 32'(CELL_SIZE)) == 32'd0) ||
                   ((y_off % 32'(CELL_SIZE)) == 32'd0);
`else
        grid_d   = 1'b0;
`endif
    end

    // Flags are registered alongside the synchronous RAM read so all
    // inputs of the colour mux line up one clock after the request.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            border_q <= 1'b0;
            grid_q   <= 1'b0;
        end else begin
            border_q <= border_d;
            grid_q   <= grid_d;
        end
    end

    logic [1:0] cell_code;

    snake_cell_ram #(.DEPTH(DEPTH)) u_cell_ram (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .we        (ram_we),
        .wr_addr   (ram_waddr),
        .wr_data   (ram_wdata),
        .rd_addr   (rd_addr),
        .rd_data   (cell_code)
    );

    always_comb begin
        if (border_q)
            pixel_data = RGB_WHITE;
        else if (grid_q && (cell_code == CELL_EMPTY))
            pixel_data = RGB_GRID;
        else
            pixel_data = cell_colour(cell_code);
    end

endmodule

// File: tb/tb_snake_pixel_gen.sv
module tb_snake_pixel_gen;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [15:0] pixel_data;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    int checks   = 0;
    int failures = 0;

    always #5 vga_clk = ~vga_clk;

    snake_pixel_gen dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_data (pixel_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int x, input int y);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 11'(a);
        wr_data = 2'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Counts clocks until clr_busy drops; bounded.
    task automatic wait_clear(output int n, output int dones);
        n = 0;
        dones = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            n++;
            if (clr_done) dones++;
            if (!clr_busy) break;
        end
    endtask

    int n, dones;

    initial begin
        sys_rst_n = 1'b0;
        pixel_xpos = '0; pixel_ypos = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
        repeat (3) step();

        chk("rst_pixel",    32'(pixel_data), 32'h0000);
        chk("rst_busy",     32'(clr_busy),   32'd1);
        chk("rst_ready",    32'(wr_ready),   32'd0);
        chk("rst_done",     32'(clr_done),   32'd0);

        // reset release: 1200-cycle clear, one done pulse
        sys_rst_n = 1'b1;
        wait_clear(n, dones);
        chk("init_clear_len",  32'(n),        32'd1200);
        chk("init_done_cnt",   32'(dones),    32'd1);
        chk("init_ready",      32'(wr_ready), 32'd1);
        step();
        chk("init_done_drop",  32'(clr_done), 32'd0);

        // head at cell 41 (row 1, col 1)
        wr(41, 2);
        req(20, 21); step();
        chk("head_41",      32'(pixel_data), 32'hFFE0);
        req(19, 21); step();
        chk("col0_border",  32'(pixel_data), 32'hFFFF);
        req(39, 40); step();
        chk("head_41_far",  32'(pixel_data), 32'hFFE0);
        req(20, 41); step();
        chk("empty_81",     32'(pixel_data), 32'h0000);

        // food at border cell 0
        wr(0, 3);
        req(0, 1); step();
        chk("border_0",     32'(pixel_data), 32'hFFFF);
        req(0, 0); step();
        chk("ypos0_border", 32'(pixel_data), 32'hFFFF);

        // out-of-range write dropped; border corners
        wr(1200, 1);
        req(799, 600); step();
        chk("border_1199",  32'(pixel_data), 32'hFFFF);
        wr(1198, 1);
        req(760, 600); step();
        chk("border_1198",  32'(pixel_data), 32'hFFFF);
        wr(42, 1);
        req(40, 21); step();
        chk("body_42",      32'(pixel_data), 32'h07E0);

        // read-old-data on same-cycle read/write of cell 85 (row 2, col 5)
        wr(85, 1);
        req(100, 41); step();
        chk("body_85",      32'(pixel_data), 32'h07E0);
        wr_en = 1'b1; wr_addr = 11'd85; wr_data = 2'd3;
        step();
        wr_en = 1'b0;
        chk("rw_old_85",    32'(pixel_data), 32'h07E0);
        step();
        chk("rw_new_85",    32'(pixel_data), 32'hF800);

        // write + clr_req together: write lands, then clear overwrites it
        wr_en = 1'b1; wr_addr = 11'd85; wr_data = 2'd2; clr_req = 1'b1;
        step();
        wr_en = 1'b0; clr_req = 1'b0;
        chk("clr_busy_on",  32'(clr_busy), 32'd1);
        chk("clr_ready_off",32'(wr_ready), 32'd0);
        n = 0; dones = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 100) begin wr_en = 1'b1; wr_addr = 11'd50; wr_data = 2'd1; end
            if (i == 101) wr_en = 1'b0;
            if (i == 200) clr_req = 1'b1;
            if (i == 201) clr_req = 1'b0;
            step();
            n++;
            if (clr_done) dones++;
            // clear at address 10 has not reached cell 85 yet
            if (n == 10) chk("display_during_clr", 32'(pixel_data), 32'hFFE0);
            if (!clr_busy) break;
        end
        chk("clr_len",      32'(n),     32'd1200);
        chk("clr_done_cnt", 32'(dones), 32'd1);
        req(100, 41); step();
        chk("cleared_85",   32'(pixel_data), 32'h0000);
        req(200, 21); step();
        chk("dropped_50",   32'(pixel_data), 32'h0000);
        req(20, 21); step();
        chk("cleared_41",   32'(pixel_data), 32'h0000);

        // reset in the middle of a clear (clear address 600)
        clr_req = 1'b1; step(); clr_req = 1'b0;
        req(0, 0);
        repeat (600) step();
        chk("pre_rst_pixel",  32'(pixel_data), 32'hFFFF);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_pixel",  32'(pixel_data), 32'h0000);
        chk("mid_rst_busy",   32'(clr_busy),   32'd1);
        chk("mid_rst_ready",  32'(wr_ready),   32'd0);
        step(); step();
        sys_rst_n = 1'b1;
        wait_clear(n, dones);
        chk("restart_len",    32'(n),        32'd1200);
        chk("restart_dones",  32'(dones),    32'd1);
        chk("restart_ready",  32'(wr_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
